// File: rtl/x_delay_decode_if.sv
// ============================================================================
// Module      : x_delay_decode_if
// Description : Bus bundle between the delay-line decoder and its environment.
//               Carries the raw snapshot, start pulse, result handshake and
//               the measurement result fields.
//               slave  modport : used by x_delay_decode
//               master modport : used by the sampler/readout side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface x_delay_decode_if #(
    parameter int LOG2_SAMPLES = 4
) ();
    logic [31:0]               i_data;     // raw sampler snapshot, every cycle
    logic                      i_start;    // begin a measurement (idle only)
    logic                      i_ready;    // consumer accepts the result
    logic                      o_busy;     // measurement in progress
    logic                      o_valid;    // result valid
    logic [6+LOG2_SAMPLES-1:0] o_sum;      // sum of positions
    logic [5:0]                o_avg;      // truncated mean position
    logic [5:0]                o_min;      // minimum position
    logic [5:0]                o_max;      // maximum position
    logic [LOG2_SAMPLES:0]     o_bubbles;  // non-monotonic snapshot count

    modport slave (
        input  i_data, i_start, i_ready,
        output o_busy, o_valid, o_sum, o_avg, o_min, o_max, o_bubbles
    );

    modport master (
        output i_data, i_start, i_ready,
        input  o_busy, o_valid, o_sum, o_avg, o_min, o_max, o_bubbles
    );
endinterface

`default_nettype wire

// File: rtl/x_delay_decode.sv
// ============================================================================
// Module      : x_delay_decode
// Description : Decodes 32-bit delay-line snapshots into an edge position
//               (0..32) and accumulates sum/min/max/bubble count over a
//               triggered window of 2^LOG2_SAMPLES snapshots. The result is
//               offered behind a valid/ready handshake.
//               Ports: i_clk, i_rst_n (async active-low),
//                      bus (x_delay_decode_if.slave): i_data, i_start,
//                      i_ready, o_busy, o_valid, o_sum, o_avg, o_min,
//                      o_max, o_bubbles
//               Option: define DL_BUBBLE_FIX_EN to report pos = popcount(t)
//                       instead of the lowest-zero index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_delay_decode #(
    parameter int LOG2_SAMPLES = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    x_delay_decode_if.slave     bus
);

    localparam int c_NSAMP   = 1 << LOG2_SAMPLES;
    localparam int c_SUM_W   = 6 + LOG2_SAMPLES;
    localparam int c_BUB_W   = LOG2_SAMPLES + 1;
    localparam int c_CNT_MAX = (FLUSH_CYCLES > c_NSAMP) ? FLUSH_CYCLES : c_NSAMP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_FLUSH_LD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FLUSH = 2'd1;
    localparam logic [1:0] c_ACCUM = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Odd stages of the delay line are inverting, so flip them to get a
    // thermometer code where 1 means "already carries the new level".
    localparam logic [31:0] c_ODD_MASK = 32'hAAAA_AAAA;

    // ------------------------------------------------------------------
    // Decode pipeline
    // ------------------------------------------------------------------
    logic [31:0] t_q;
    logic [5:0]  pos_q, pos_d;
    logic        bubble_q, bubble_d;
    logic [5:0]  w_lz;
    logic        w_found;
    logic [5:0]  w_pop;

    always_comb begin
        w_lz    = 6'd32;
        w_found = 1'b0;
        w_pop   = 6'd0;
        for (int k = 0; k < 32; k++) begin
            if (!w_found && !t_q[k]) begin
                w_lz    = 6'(k);
                w_found = 1'b1;
            end
            w_pop = w_pop + {5'd0, t_q[k]};
        end
        // Adding one clears the run of trailing ones and sets the lowest
        // zero; the AND then leaves only the bits above the lowest zero.
        bubble_d = |(t_q & (t_q + 32'd1));
`ifdef DL_BUBBLE_FIX_EN
        pos_d    = w_pop;
`else
        pos_d    = w_lz;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            t_q      <= 32'd0;
            pos_q    <= 6'd0;
            bubble_q <= 1'b0;
        end else begin
            t_q      <= bus.i_data ^ c_ODD_MASK;
            pos_q    <= pos_d;
            bubble_q <= bubble_d;
        end
    end

    // ------------------------------------------------------------------
    // Window control and accumulation
    // ------------------------------------------------------------------
    logic [1:0]          state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [c_SUM_W-1:0]  acc_sum_q, acc_sum_d, w_sum_nxt;
    logic [5:0]          acc_min_q, acc_min_d, w_min_nxt;
    logic [5:0]          acc_max_q, acc_max_d, w_max_nxt;
    logic [c_BUB_W-1:0]  acc_bub_q, acc_bub_d, w_bub_nxt;
    logic [c_SUM_W-1:0]  res_sum_q, res_sum_d;
    logic [5:0]          res_min_q, res_min_d;
    logic [5:0]          res_max_q, res_max_d;
    logic [c_BUB_W-1:0]  res_bub_q, res_bub_d;
    logic                res_seen_q, res_seen_d;

    assign w_sum_nxt = acc_sum_q + c_SUM_W'(pos_q);
    assign w_min_nxt = (pos_q < acc_min_q) ? pos_q : acc_min_q;
    assign w_max_nxt = (pos_q > acc_max_q) ? pos_q : acc_max_q;
    assign w_bub_nxt = acc_bub_q + c_BUB_W'(bubble_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_sum_d  = acc_sum_q;
        acc_min_d  = acc_min_q;
        acc_max_d  = acc_max_q;
        acc_bub_d  = acc_bub_q;
        res_sum_d  = res_sum_q;
        res_min_d  = res_min_q;
        res_max_d  = res_max_q;
        res_bub_d  = res_bub_q;
        res_seen_d = res_seen_q;
        case (state_q)
            c_IDLE: begin
                if (bus.i_start) begin
                    acc_sum_d = '0;
                    acc_min_d = 6'd32;
                    acc_max_d = 6'd0;
                    acc_bub_d = '0;
                    if (FLUSH_CYCLES == 0) begin
                        state_d = c_ACCUM;
                        cnt_d   = c_CNT_W'(c_NSAMP - 1);
                    end else begin
                        state_d = c_FLUSH;
                        cnt_d   = c_CNT_W'(c_FLUSH_LD);
                    end
                end
            end
            c_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = c_ACCUM;
                    cnt_d   = c_CNT_W'(c_NSAMP - 1);
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            c_ACCUM: begin
                acc_sum_d = w_sum_nxt;
                acc_min_d = w_min_nxt;
                acc_max_d = w_max_nxt;
                acc_bub_d = w_bub_nxt;
                if (cnt_q == '0) begin
                    // Publish including the final sample in the same edge.
                    state_d    = c_DONE;
                    res_sum_d  = w_sum_nxt;
                    res_min_d  = w_min_nxt;
                    res_max_d  = w_max_nxt;
                    res_bub_d  = w_bub_nxt;
                    res_seen_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin // c_DONE
                if (bus.i_ready) begin
                    state_d = c_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= c_IDLE;
            cnt_q      <= '0;
            acc_sum_q  <= '0;
            acc_min_q  <= 6'd32;
            acc_max_q  <= 6'd0;
            acc_bub_q  <= '0;
            res_sum_q  <= '0;
            res_min_q  <= 6'd32;
            res_max_q  <= 6'd0;
            res_bub_q  <= '0;
            res_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_sum_q  <= acc_sum_d;
            acc_min_q  <= acc_min_d;
            acc_max_q  <= acc_max_d;
            acc_bub_q  <= acc_bub_d;
            res_sum_q  <= res_sum_d;
            res_min_q  <= res_min_d;
            res_max_q  <= res_max_d;
            res_bub_q  <= res_bub_d;
            res_seen_q <= res_seen_d;
        end
    end

    assign bus.o_busy    = (state_q == c_FLUSH) || (state_q == c_ACCUM);
    assign bus.o_valid   = (state_q == c_DONE);
    assign bus.o_sum     = res_sum_q;
    assign bus.o_avg     = res_sum_q[LOG2_SAMPLES +: 6];
    // The internal minimum idles at 32; the port shows 0 until a result exists.
    assign bus.o_min     = res_seen_q ? res_min_q : 6'd0;
    assign bus.o_max     = res_max_q;
    assign bus.o_bubbles = res_bub_q;

endmodule

`default_nettype wire

// File: tb/tb_x_delay_decode.sv
// ============================================================================
// Module      : tb_x_delay_decode
// Description : Self-checking bench for x_delay_decode with a scoreboard of
//               expected window results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_x_delay_decode;

    localparam int c_L = 4;
    localparam int c_N = 16;

    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] avg;
        logic [31:0] min;
        logic [31:0] max;
        logic [31:0] bub;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_a, d_b;
    logic        ph;
    int          n_checks;
    int          n_pass;
    exp_t        sb[$];

    x_delay_decode_if #(.LOG2_SAMPLES(c_L)) bus ();

    x_delay_decode #(.LOG2_SAMPLES(c_L), .FLUSH_CYCLES(3)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot source: alternates between d_a and d_b every cycle.
    initial begin
        ph = 1'b0;
        bus.i_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_data = ph ? d_b : d_a;
            ph = ~ph;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference decode of one raw snapshot.
    function automatic void model(input logic [31:0] d, output int pos, output int bub);
        logic [31:0] t;
        int lz, pc;
        t  = d ^ 32'hAAAA_AAAA;
        lz = 32;
        pc = 0;
        bub = 0;
        for (int k = 31; k >= 0; k--) if (!t[k]) lz = k;
        for (int k = 0; k < 32; k++) begin
            if (t[k]) pc++;
            if (k > lz && t[k]) bub = 1;
        end
`ifdef DL_BUBBLE_FIX_EN
        pos = pc;
`else
        pos = lz;
`endif
    endfunction

    task automatic measure(input logic [31:0] a, input logic [31:0] b, input int hold);
        int   pa, ba, pb, bb, cyc;
        exp_t e;
        d_a = a;
        d_b = b;
        repeat (4) @(negedge clk);
        model(a, pa, ba);
        model(b, pb, bb);
        e.sum = 32'((c_N / 2) * (pa + pb));
        e.avg = e.sum >> c_L;
        e.min = 32'((pa < pb) ? pa : pb);
        e.max = 32'((pa > pb) ? pa : pb);
        e.bub = 32'((c_N / 2) * (ba + bb));
        sb.push_back(e);

        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cyc = 1;
        chk("busy_after_start", {31'd0, bus.o_busy}, 32'd1);
        while (!bus.o_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("start_to_valid", cyc, 32'd20);
        chk("busy_in_done", {31'd0, bus.o_busy}, 32'd0);

        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sum", {26'd0, bus.o_sum}, e.sum);
            chk("avg", {26'd0, bus.o_avg}, e.avg);
            chk("min", {26'd0, bus.o_min}, e.min);
            chk("max", {26'd0, bus.o_max}, e.max);
            chk("bubbles", {27'd0, bus.o_bubbles}, e.bub);
        end

        // Back-pressure with stray start pulses: everything must hold.
        for (int i = 0; i < hold; i++) begin
            bus.i_start = (i % 3 == 1);
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.o_valid}, 32'd1);
            chk("hold_sum", {26'd0, bus.o_sum}, e.sum);
        end

        // Handshake with a coincident start, which must be ignored.
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_start = 1'b0;
        chk("valid_after_ack", {31'd0, bus.o_valid}, 32'd0);
        chk("busy_after_ack", {31'd0, bus.o_busy}, 32'd0);
        chk("sum_retained", {26'd0, bus.o_sum}, e.sum);
        repeat (2) @(negedge clk);
        chk("idle_stays_idle", {31'd0, bus.o_busy}, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        d_a         = 32'd0;
        d_b         = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("rst_sum", {26'd0, bus.o_sum}, 32'd0);
        chk("rst_min", {26'd0, bus.o_min}, 32'd0);
        chk("rst_max", {26'd0, bus.o_max}, 32'd0);
        chk("rst_bubbles", {27'd0, bus.o_bubbles}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        measure(32'hAAAA_A955, 32'hAAAA_A955, 10);
        chk("tp_sum_3ff", {26'd0, bus.o_sum}, 32'd160);
        chk("tp_avg_3ff", {26'd0, bus.o_avg}, 32'd10);

        measure(32'h5555_5555, 32'h5555_5555, 2);
        chk("tp_avg_full", {26'd0, bus.o_avg}, 32'd32);
        chk("tp_sum_full", {26'd0, bus.o_sum}, 32'd512);

        measure(32'hAAAA_AAAA, 32'hAAAA_AAAA, 2);
        chk("tp_avg_zero", {26'd0, bus.o_avg}, 32'd0);
        chk("tp_min_zero", {26'd0, bus.o_min}, 32'd0);

        measure(32'hAAAA_AA55, 32'hAAAA_A555, 2);
        chk("tp_alt_min", {26'd0, bus.o_min}, 32'd8);
        chk("tp_alt_max", {26'd0, bus.o_max}, 32'd12);

        measure(32'hAAAA_A975, 32'hAAAA_A975, 2);
        chk("tp_bubbles", {27'd0, bus.o_bubbles}, 32'd16);
`ifdef DL_BUBBLE_FIX_EN
        chk("tp_bubble_avg", {26'd0, bus.o_avg}, 32'd9);
`else
        chk("tp_bubble_avg", {26'd0, bus.o_avg}, 32'd5);
`endif

        // Abort a measurement mid-window.
        d_a = 32'hAAAA_A955;
        d_b = 32'hAAAA_A955;
        repeat (2) @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_mid_accum", {31'd0, bus.o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("abort_sum", {26'd0, bus.o_sum}, 32'd0);
        chk("abort_min", {26'd0, bus.o_min}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_restart", {31'd0, bus.o_busy}, 32'd0);
        measure(32'hAAAA_A955, 32'hAAAA_A955, 1);
        chk("post_reset_sum", {26'd0, bus.o_sum}, 32'd160);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
